// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, shadow layout.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Result waiting to be committed; wr is cleared for divide-by-zero so HI/LO hold.
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } shadow_t;

endpackage

// File: rtl/mdu_if.sv
// Issuer-side bus of the MDU: request, operands and architectural read-back.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  op_e         mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] res;

  modport master (output start, mdu_op, A, B, input busy, HI, LO, res);
  modport slave  (input start, mdu_op, A, B, output busy, HI, LO, res);
endinterface

// File: rtl/mdu_div.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient/remainder.
module mdu_div (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        dz_o
);
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_u, r_u;

  // Work on magnitudes; 0x80000000 negates to itself and is a valid unsigned magnitude,
  // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign neg_a = signed_i & a_i[31];
  assign neg_b = signed_i & b_i[31];
  assign mag_a = neg_a ? (32'd0 - a_i) : a_i;
  assign mag_b = neg_b ? (32'd0 - b_i) : b_i;
  assign dz_o  = (b_i == 32'd0);

  // Guard the zero divisor so no X/undefined value ever reaches the shadow.
  assign q_u = dz_o ? 32'd0 : (mag_a / mag_b);
  assign r_u = dz_o ? 32'd0 : (mag_a % mag_b);

  // Quotient sign from operand signs; remainder follows the dividend.
  assign quo_o = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
  assign rem_o = neg_a ? (32'd0 - r_u) : r_u;
endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a fixed busy window.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  shadow_t            shadow_q, shadow_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic               is_idle, launch_mul, launch_div, commit, wr_hi, wr_lo;
  logic [63:0]        a_ext, b_ext, prod;
  logic [31:0]        quo, rem;
  logic               dz;

  assign is_idle    = (state_q == ST_IDLE);
  assign launch_mul = is_idle && bus.start && (bus.mdu_op == OP_MULT || bus.mdu_op == OP_MULTU);
  assign launch_div = is_idle && bus.start && (bus.mdu_op == OP_DIV  || bus.mdu_op == OP_DIVU);
  assign wr_hi      = is_idle && bus.start && (bus.mdu_op == OP_MTHI);
  assign wr_lo      = is_idle && bus.start && (bus.mdu_op == OP_MTLO);
  assign commit     = !is_idle && (cnt_q == CNT_W'(1));

  // Full 64-bit product: sign- or zero-extend, low 64 bits are the exact result either way.
  assign a_ext = (bus.mdu_op == OP_MULT) ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
  assign b_ext = (bus.mdu_op == OP_MULT) ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
  assign prod  = (bus.mdu_op == OP_MULT) ? 64'($signed(a_ext) * $signed(b_ext)) : (a_ext * b_ext);

  mdu_div u_div (
    .a_i      (bus.A),
    .b_i      (bus.B),
    .signed_i (bus.mdu_op == OP_DIV),
    .quo_o    (quo),
    .rem_o    (rem),
    .dz_o     (dz)
  );

  // State register plus counter, shadow and HI/LO, all cleared by async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state: launch from IDLE, return to IDLE on the commit edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_mul)      state_d = ST_MUL;
        else if (launch_div) state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (commit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output: busy for the whole MUL/DIV residency.
  always_comb begin
    bus.busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  end

  // Datapath next values: latch result at launch, count down, commit or direct writes.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (launch_mul) begin
      cnt_d    = CNT_W'(MULT_CYCLES);
      shadow_d = '{wr: 1'b1, hi: prod[63:32], lo: prod[31:0]};
    end else if (launch_div) begin
      cnt_d    = CNT_W'(DIV_CYCLES);
      shadow_d = '{wr: !dz, hi: rem, lo: quo};
    end else if (!is_idle) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (commit && shadow_q.wr) begin
        hi_d = shadow_q.hi;
        lo_d = shadow_q.lo;
      end
    end
    if (wr_hi) hi_d = bus.A;
    if (wr_lo) lo_d = bus.A;
  end

  // Architectural read-back; res is a pure mux on the current op.
  always_comb begin
    bus.HI  = hi_q;
    bus.LO  = lo_q;
    bus.res = (bus.mdu_op == OP_MFHI) ? hi_q :
              (bus.mdu_op == OP_MFLO) ? lo_q : 32'd0;
  end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu with a queue of expected commits.
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  exp_t  sb[$];
  int    n_asrt = 0;
  int    n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Called at a negedge: present the request for one edge, then scramble operands.
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
    bus.A      = $urandom;
    bus.B      = $urandom;
  endtask

  // Count busy cycles, optionally poke ignored requests, then compare against the queue head.
  task automatic wait_done(input bit disturb);
    exp_t e;
    int   cnt;
    bit   poke;
    if (sb.size() == 0) begin
      check("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e   = sb.pop_front();
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 1) begin
        bus.mdu_op = OP_MFLO;
        #1;
        check({e.tag, "_rd_busy"}, 64'(bus.res), 64'(m_lo));
      end
      poke = disturb && (cnt == 2 || cnt == 4 || cnt == e.cyc);
      bus.start  = poke;
      bus.mdu_op = (disturb && cnt == 4) ? OP_MTLO : (poke ? OP_MULT : OP_NOP);
      bus.A      = (disturb && cnt == 4) ? 32'hDEAD : 32'd5;
      bus.B      = 32'd5;
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
    check({e.tag, "_cycles"}, 64'(cnt), 64'(e.cyc));
    check({e.tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
    check({e.tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  initial begin
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.mdu_op = OP_MFHI;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    check("rst_res", 64'(bus.res), 64'd0);
    reset      = 1'b1;
    bus.mdu_op = OP_NOP;

    // First request right after reset release.
    expect_op("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_done(1'b0);

    expect_op("multu", 32'h00000001, 32'hFFFFFFFE, 5);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_done(1'b0);

    expect_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0);

    expect_op("divu", 32'd1, 32'd3, 10);
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_done(1'b0);

    // NOP with start changes nothing.
    issue(OP_NOP, 32'h11111111, 32'h22222222);
    check("nop_busy", 64'(bus.busy), 64'd0);
    check("nop_hi", 64'(bus.HI), 64'(m_hi));
    check("nop_lo", 64'(bus.LO), 64'(m_lo));

    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi", 64'(bus.HI), 64'h1234);
    bus.mdu_op = OP_MFHI;
    #1;
    check("mfhi_res", 64'(bus.res), 64'h1234);
    @(negedge clk);
    m_hi = 32'h1234;

    // Divide by zero keeps HI/LO; MULT/MTLO during busy and MULT at commit are ignored.
    expect_op("div0", 32'h1234, m_lo, 10);
    issue(OP_DIV, 32'd99, 32'd0);
    wait_done(1'b1);
    @(negedge clk);
    check("div0_after_busy", 64'(bus.busy), 64'd0);

    expect_op("div_ovf", 32'h00000000, 32'h80000000, 10);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0);

    // Abort a divide in its fourth busy cycle.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.HI), 64'd0);
    check("abort_lo", 64'(bus.LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(OP_MTLO, 32'h55, 32'd0);
    check("mtlo_lo", 64'(bus.LO), 64'h55);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    bus.mdu_op = OP_MFLO;
    #1;
    check("mflo_res", 64'(bus.res), 64'h55);
    repeat (12) @(negedge clk);
    check("abort_no_commit_hi", 64'(bus.HI), 64'd0);
    check("abort_no_commit_lo", 64'(bus.LO), 64'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request that launches the operation on mdu_op.
REQ-006 mdu_op  input  4  operation code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 A  input  32  first operand: multiplicand/dividend, or the write data for MTHI/MTLO.
REQ-008 B  input  32  second operand: multiplier/divisor.
REQ-009 busy  output  1  high while a multiply or divide is in flight.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.
REQ-012 res  output  32  read data: HI when mdu_op=MFHI, LO when mdu_op=MFLO, else 0; combinational.

Function
REQ-013 State machine has three states: IDLE, MUL, DIV; the reset state is IDLE.
REQ-014 IDLE with start=1 and MULT/MULTU: latch the 64-bit product (signed or unsigned) into a shadow register and load the counter with MULT_CYCLES; next state MUL.
REQ-015 IDLE with start=1 and DIV/DIVU: latch quotient and remainder into the shadow register and load the counter with DIV_CYCLES; next state DIV.
REQ-016 busy SHALL be 1 exactly when the state is MUL or DIV, i.e. for N consecutive cycles starting the cycle after start.
REQ-017 In MUL/DIV the counter decrements each cycle; at the edge where the counter is 1, the shadow is committed to HI/LO and the state returns to IDLE.
REQ-018 MULT/MULTU commit: HI = product[63:32], LO = product[31:0].
REQ-019 DIV/DIVU commit: LO = quotient, HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
REQ-021 Divide by zero (B=0): the full DIV_CYCLES busy period still runs, and HI/LO keep their prior values.
REQ-022 MTHI/MTLO in IDLE write A into HI/LO at the next edge; busy is not asserted.
REQ-023 While busy=1: start is ignored for every op, and MTHI/MTLO do not write; the issuer stalls these ops.
REQ-024 MFHI/MFLO while busy=1 return the pre-commit HI/LO; the issuer stalls them.
REQ-025 Operands are sampled only at the start edge; changes on A/B during busy have no effect.
REQ-026 Start in the same cycle as commit (state MUL/DIV, counter=1) is ignored.
REQ-027 NOP, or start=0, in IDLE changes nothing.

Reset
REQ-028 On reset=0, immediately: state=IDLE, counter=0, shadow=0, HI=0, LO=0, busy=0.
REQ-029 Reset asserted mid-operation aborts it with no commit.
REQ-030 After reset deasserts, the first start is accepted on the next edge.

Structure
REQ-031 A shared macro/package file holds the mdu_op encodings and the MUL/DIV/IDLE state encodings; the decoder uses the same encodings.
REQ-032 One sub-module, mdu_div, computes the signed/unsigned quotient/remainder combinationally, including the REQ-020 case.
REQ-033 Multiply is implemented inline with $signed/unsigned 64-bit products.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-037 MTHI 0x1234 then DIV with B=0 -> busy for 10 cycles, HI remains 0x1234; start MULT during busy is ignored.
REQ-038 Reset pulsed in DIV cycle 4 -> busy=0 and HI=LO=0 immediately; MTLO 0x55 next -> LO=0x55, MFLO res=0x55.
REQ-039 Signed 0x80000000 / -1 -> LO=0x80000000, HI=0, no X values.
